// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dmem_state_t;

    typedef struct packed {
        logic                   write;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane-enabled word storage; synchronous write, registered read on the access edge.
// Contents are never reset; the read register only updates on loads so it holds between them.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [DMEM_BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] rdata_o
);

    logic [DMEM_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DMEM_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DMEM_BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, WAIT_CYCLES wait states, single-cycle response.
// Optional address fault checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [DMEM_ADDR_W-1:0] req_addr_i,
    input  logic [DMEM_DATA_W-1:0] req_wdata_i,
    input  logic [DMEM_BE_W-1:0]   req_be_i,
    output logic                   rsp_valid_o,
    output logic [DMEM_DATA_W-1:0] rsp_rdata_o,
    output logic                   rsp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_zero_q, rsp_zero_d;

    dmem_req_t   req_in;
    dmem_req_t   acc;
    logic        acc_fire;
    logic        acc_from_req;
    logic        acc_err;
    logic [DMEM_DATA_W-1:0] arr_rdata;

    assign req_in = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        rsp_valid_d  = 1'b0;
        acc_fire     = 1'b0;
        acc_from_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d = req_in;
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the access happens on the accept edge itself.
                        state_d      = ST_RESP;
                        acc_fire     = 1'b1;
                        acc_from_req = 1'b1;
                        rsp_valid_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = ST_RESP;
                    acc_fire    = 1'b1;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign acc = acc_from_req ? req_in : req_q;

`ifdef DMEM_ERR_CHECK_EN
    logic rsp_err_q, rsp_err_d;

    assign acc_err = (acc.addr[1:0] != 2'b00) ||
                     ({2'b00, acc.addr[DMEM_ADDR_W-1:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (acc_fire) begin
            rsp_err_d = acc_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    logic unused_addr_bits;

    assign acc_err          = 1'b0;
    assign rsp_err_o        = 1'b0;
    assign unused_addr_bits = ^{acc.addr[1:0], acc.addr[DMEM_ADDR_W-1:2+IDX_W]};
`endif

    // Stores and faulted requests report zero data; this flag masks the array's read register.
    always_comb begin
        rsp_zero_d = rsp_zero_q;
        if (acc_fire) begin
            rsp_zero_d = acc.write | acc_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (acc_fire & ~acc_err),
        .we_i    (acc.write),
        .be_i    (acc.be),
        .idx_i   (acc.addr[2 +: IDX_W]),
        .wdata_i (acc.wdata),
        .rdata_o (arr_rdata)
    );

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        a_valid, z_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        a_ready, a_rsp_valid, a_err;
    logic [31:0] a_rdata;
    logic        z_ready, z_rsp_valid, z_err;
    logic [31:0] z_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    logic [31:0] hs_addr [3];
    logic [31:0] hs_exp  [3];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (a_valid),
        .req_ready_o (a_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (a_rsp_valid),
        .rsp_rdata_o (a_rdata),
        .rsp_err_o   (a_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (z_valid),
        .req_ready_o (z_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (z_rsp_valid),
        .rsp_rdata_o (z_rdata),
        .rsp_err_o   (z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; inputs are scrambled right after the accept edge.
    task automatic xfer(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input string tag,
                        output logic [31:0] rdo, output logic erro);
        int wc;
        wc   = sel ? 0 : 2;
        rdo  = 'x;
        erro = 1'bx;
        @(negedge clk);
        check({tag, " ready_before"}, sel ? z_ready : a_ready, 32'd1);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        if (sel) z_valid = 1'b1; else a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid   = 1'b0;
        z_valid   = 1'b0;
        req_write = ~w;
        req_addr  = a ^ 32'h0000_0ff0;
        req_wdata = ~d;
        req_be    = ~be;
        for (int k = 1; k <= wc + 2; k++) begin
            @(negedge clk);
            check($sformatf("%s rsp_valid c%0d", tag, k), sel ? z_rsp_valid : a_rsp_valid, 32'(k == wc + 1));
            check($sformatf("%s ready c%0d", tag, k), sel ? z_ready : a_ready, 32'(k == wc + 2));
            if (k == wc + 1) begin
                rdo  = sel ? z_rdata : a_rdata;
                erro = sel ? z_err : a_err;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        z_valid   = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        hs_addr[0] = 32'h10; hs_exp[0] = 32'hDEADBEEF;
        hs_addr[1] = 32'h20; hs_exp[1] = 32'h11BB33DD;
        hs_addr[2] = 32'h10; hs_exp[2] = 32'hDEADBEEF;

        #1;
        check("reset ready", a_ready, 32'd1);
        check("reset rsp_valid", a_rsp_valid, 32'd0);
        check("reset rdata", a_rdata, 32'd0);
        check("reset err", a_err, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic store then load
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10", rd, er);
        check("st10 rdata", rd, 32'd0);
        check("st10 err", er, 32'd0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10", rd, er);
        check("ld10 rdata", rd, 32'hDEADBEEF);
        check("ld10 err", er, 32'd0);

        // Byte-enable merge
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "st20a", rd, er);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "st20b", rd, er);
        check("st20b rdata", rd, 32'd0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, "ld20", rd, er);
        check("ld20 merged", rd, 32'h11BB33DD);
        @(negedge clk);
        check("rdata hold", a_rdata, 32'h11BB33DD);

        // Valid held high: one accept every four cycles, mid-flight input changes ignored
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("hs ready c%0d", i), a_ready, 32'(i % 4 == 0));
            check($sformatf("hs rsp_valid c%0d", i), a_rsp_valid, 32'(i % 4 == 3));
            if (i % 4 == 3) begin
                check($sformatf("hs rdata c%0d", i), a_rdata, hs_exp[i / 4]);
            end
            if (i % 4 == 0) begin
                a_valid   = 1'b1;
                req_write = 1'b0;
                req_addr  = hs_addr[i / 4];
                req_be    = 4'h0;
            end else if (i % 4 == 1) begin
                req_write = 1'b1;
                req_addr  = 32'h30;
                req_wdata = 32'h0F0F0F0F;
                req_be    = 4'hF;
            end
        end
        @(negedge clk);
        check("hs ready end", a_ready, 32'd1);
        a_valid = 1'b0;

        // Faults / aliasing
        xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, "st0", rd, er);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10b", rd, er);
        check("ld10b rdata", rd, 32'hDEADBEEF);
`ifdef DMEM_ERR_CHECK_EN
        xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, "ld13", rd, er);
        check("ld13 err", er, 32'd1);
        check("ld13 rdata", rd, 32'd0);
        xfer(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, "st400", rd, er);
        check("st400 err", er, 32'd1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, "ld0", rd, er);
        check("ld0 unchanged", rd, 32'h01020304);
        check("ld0 err", er, 32'd0);
`else
        xfer(0, 1'b0, 32'h13, 32'h0, 4'h0, "ld13", rd, er);
        check("ld13 err", er, 32'd0);
        check("ld13 rdata", rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, "st400", rd, er);
        check("st400 err", er, 32'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, "ld0", rd, er);
        check("ld0 aliased", rd, 32'hCAFEF00D);
`endif

        // Reset while the response pulse is high
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 32'h20;
        a_valid   = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstresp pulse", a_rsp_valid, 32'd1);
        check("rstresp rdata", a_rdata, 32'h11BB33DD);
        rst = 1'b1;
        #1;
        check("rstresp valid drop", a_rsp_valid, 32'd0);
        check("rstresp rdata clr", a_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in WAIT abandons the store
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h55555555;
        req_be    = 4'hF;
        a_valid   = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        check("rstwait in wait", a_ready, 32'd0);
        rst = 1'b1;
        #1;
        check("rstwait ready", a_ready, 32'd1);
        check("rstwait rsp_valid", a_rsp_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstwait no pulse c%0d", i), a_rsp_valid, 32'd0);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld10c", rd, er);
        check("ld10c kept", rd, 32'hDEADBEEF);

        // Zero wait states
        xfer(1, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, "zst8", rd, er);
        check("zst8 rdata", rd, 32'd0);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, "zld8", rd, er);
        check("zld8 rdata", rd, 32'h0BADCAFE);
        check("zld8 err", er, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
